stage_fetch0: RTL and testbench

- First instruction-fetch stage. Owns the architectural fetch PC and the speculation ID, and issues the I-cache CAM index read for the address it hands to the second fetch stage.
- Applies redirects from execute (branch mispredict) and CSR (trap/xret kill).
- Runs the fence.i I-cache invalidation sweep.
- Sits directly upstream of the second fetch stage, which captures fe0_valid, fe0_specid and fe0_read_addr when not stalled.

---
 rtl/stage_fetch0.sv | 119 +++++++++++
 tb/tb_stage_fetch0.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/stage_fetch0.sv
//==============================================================================
// stage_fetch0 : first fetch stage - fetch PC, speculation ID, CAM read/inval
// Revision 1.0 : initial release
//==============================================================================
`default_nettype none

module stage_fetch0 #(
    parameter logic [31:0] RESET_PC   = 32'h1000_0000,
    parameter int          INDEX_BITS = 8
) (
    input  logic                  clk_core,
    input  logic                  reset_n,
    output logic                  fe0_valid,
    output logic                  fe0_specid,
    output logic [29:0]           fe0_read_addr,
    input  logic                  fe1_stall,
    output logic                  fe0_cam_read_req,
    output logic [9:0]            fe0_cam_read_addr,
    output logic                  fe0_cam_inval_req,
    output logic [INDEX_BITS-1:0] fe0_cam_inval_index,
    input  logic                  ex_redirect,
    input  logic [29:0]           ex_redirect_pc,
    input  logic                  ex_fencei,
    input  logic                  csr_kill,
    input  logic [29:0]           csr_redirect_pc,
    output logic                  fe0_fencei_done
);

    localparam logic [29:0] RESET_WORD = RESET_PC[31:2];

    typedef enum logic [2:0] {
        ST_RST   = 3'b001,
        ST_RUN   = 3'b010,
        ST_FLUSH = 3'b100
    } state_t;

    state_t                state, state_nxt;
    logic [29:0]           pc, pc_nxt;
    logic [29:0]           last_pc, last_pc_nxt;
    logic                  specid, specid_nxt;
    logic [INDEX_BITS-1:0] count, count_nxt;
    logic                  redirect;

    assign redirect            = csr_kill | ex_redirect;
    assign fe0_read_addr       = pc;
    assign fe0_specid          = specid;
    assign fe0_cam_inval_index = count;
    // During a stall, re-read the set the second stage is holding
    assign fe0_cam_read_addr   = fe1_stall ? last_pc[9:0] : pc[9:0];

    always_ff @(posedge clk_core) begin
        if (!reset_n) begin
            state   <= ST_RST;
            pc      <= RESET_WORD;
            last_pc <= RESET_WORD;
            specid  <= 1'b0;
            count   <= '0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            last_pc <= last_pc_nxt;
            specid  <= specid_nxt;
            count   <= count_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        pc_nxt            = pc;
        last_pc_nxt       = last_pc;
        specid_nxt        = specid;
        count_nxt         = count;
        fe0_valid         = 1'b0;
        fe0_cam_read_req  = 1'b0;
        fe0_cam_inval_req = 1'b0;
        fe0_fencei_done   = 1'b0;
        case (state)
            ST_RST: begin
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                fe0_cam_read_req = 1'b1;
                fe0_valid        = ~redirect;
                if (csr_kill) begin
                    pc_nxt = csr_redirect_pc;
                end else if (ex_redirect && ex_fencei) begin
                    pc_nxt     = ex_redirect_pc;
                    specid_nxt = ~specid;
                    count_nxt  = '0;
                    state_nxt  = ST_FLUSH;
                end else if (ex_redirect) begin
                    pc_nxt     = ex_redirect_pc;
                    specid_nxt = ~specid;
                end else if (!fe1_stall) begin
                    last_pc_nxt = pc;
                    pc_nxt      = pc + 30'd1;
                end
            end
            ST_FLUSH: begin
                fe0_cam_inval_req = 1'b1;
                count_nxt         = count + INDEX_BITS'(1);
                if (csr_kill) begin
                    pc_nxt = csr_redirect_pc;
                end
                // Last set of the sweep: counter wraps to 0 on its own
                if (&count) begin
                    fe0_fencei_done = 1'b1;
                    state_nxt       = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_RST;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_stage_fetch0.sv
//==============================================================================
// tb_stage_fetch0 : self-checking bench for stage_fetch0
// Revision 1.0 : initial release
//==============================================================================
`default_nettype none

module tb_stage_fetch0;

    logic        clk_core = 1'b0;
    logic        reset_n;
    logic        fe0_valid, fe0_specid, fe0_cam_read_req, fe0_cam_inval_req, fe0_fencei_done;
    logic [29:0] fe0_read_addr;
    logic [9:0]  fe0_cam_read_addr;
    logic [7:0]  fe0_cam_inval_index;
    logic        fe1_stall, ex_redirect, ex_fencei, csr_kill;
    logic [29:0] ex_redirect_pc, csr_redirect_pc;

    int n_tests = 0;
    int n_fail  = 0;

    stage_fetch0 #(.RESET_PC(32'h1000_0000), .INDEX_BITS(8)) dut (
        .clk_core(clk_core), .reset_n(reset_n),
        .fe0_valid(fe0_valid), .fe0_specid(fe0_specid), .fe0_read_addr(fe0_read_addr),
        .fe1_stall(fe1_stall),
        .fe0_cam_read_req(fe0_cam_read_req), .fe0_cam_read_addr(fe0_cam_read_addr),
        .fe0_cam_inval_req(fe0_cam_inval_req), .fe0_cam_inval_index(fe0_cam_inval_index),
        .ex_redirect(ex_redirect), .ex_redirect_pc(ex_redirect_pc), .ex_fencei(ex_fencei),
        .csr_kill(csr_kill), .csr_redirect_pc(csr_redirect_pc),
        .fe0_fencei_done(fe0_fencei_done)
    );

    always #5 clk_core = ~clk_core;

    // Reference model: mode -1 unknown, 0 bubble, 1 fetching, 2 sweeping
    int          m_mode = -1;
    logic [29:0] m_pc, m_last;
    logic        m_spec;
    int          m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic tick_check();
        logic redir;
        @(negedge clk_core);
        if (m_mode >= 0) begin
            redir = csr_kill | ex_redirect;
            chk("valid",     32'(fe0_valid),         32'((m_mode == 1) && !redir));
            chk("read_addr", 32'(fe0_read_addr),     32'(m_pc));
            chk("specid",    32'(fe0_specid),        32'(m_spec));
            chk("read_req",  32'(fe0_cam_read_req),  32'(m_mode == 1));
            chk("cam_addr",  32'(fe0_cam_read_addr), fe1_stall ? 32'(m_last % 1024) : 32'(m_pc % 1024));
            chk("inval_req", 32'(fe0_cam_inval_req), 32'(m_mode == 2));
            chk("done",      32'(fe0_fencei_done),   32'((m_mode == 2) && (m_cnt == 255)));
            if (m_mode == 2) chk("inval_index", 32'(fe0_cam_inval_index), 32'(m_cnt));
        end
    endtask

    task automatic tick_adv();
        @(posedge clk_core);
        if (!reset_n) begin
            m_mode = 0; m_pc = 30'h0400_0000; m_last = 30'h0400_0000; m_spec = 1'b0; m_cnt = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (csr_kill) m_pc = csr_redirect_pc;
            else if (ex_redirect) begin
                m_pc = ex_redirect_pc; m_spec = ~m_spec;
                if (ex_fencei) begin m_mode = 2; m_cnt = 0; end
            end else if (!fe1_stall) begin
                m_last = m_pc; m_pc = 30'((64'(m_pc) + 1) % (64'd1 << 30));
            end
        end else if (m_mode == 2) begin
            if (csr_kill) m_pc = csr_redirect_pc;
            if (m_cnt == 255) begin m_cnt = 0; m_mode = 1; end
            else m_cnt++;
        end
        #1;
    endtask

    task automatic idle_inputs();
        fe1_stall = 0; ex_redirect = 0; ex_fencei = 0; csr_kill = 0;
        ex_redirect_pc = '0; csr_redirect_pc = '0;
    endtask

    typedef struct {
        logic        stall, exr, kill;
        logic [29:0] exr_pc, kill_pc;
        logic        e_valid, e_spec, e_inval;
        logic [29:0] e_addr;
        logic [9:0]  e_cam;
    } vec_t;

    vec_t vecs[12];

    initial begin
        //            stall exr kill exr_pc       kill_pc      valid spec inval addr          cam
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 30'h0,     30'h0,     1'b0, 1'b0, 1'b0, 30'h0400_0000, 10'h000};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 30'h0,     30'h0,     1'b1, 1'b0, 1'b0, 30'h0400_0000, 10'h000};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 30'h0,     30'h0,     1'b1, 1'b0, 1'b0, 30'h0400_0001, 10'h001};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 30'h0,     30'h0,     1'b1, 1'b0, 1'b0, 30'h0400_0002, 10'h001};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 30'h0,     30'h0,     1'b1, 1'b0, 1'b0, 30'h0400_0002, 10'h001};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 30'h0,     30'h0,     1'b1, 1'b0, 1'b0, 30'h0400_0002, 10'h001};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 30'h0,     30'h0,     1'b1, 1'b0, 1'b0, 30'h0400_0002, 10'h002};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 30'h100,   30'h0,     1'b0, 1'b0, 1'b0, 30'h0400_0003, 10'h002};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 30'h0,     30'h0,     1'b1, 1'b1, 1'b0, 30'h0000_0100, 10'h100};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 30'h300,   30'h200,   1'b0, 1'b1, 1'b0, 30'h0000_0101, 10'h101};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 30'h0,     30'h0,     1'b1, 1'b1, 1'b0, 30'h0000_0200, 10'h200};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 30'h0,     30'h0,     1'b1, 1'b1, 1'b0, 30'h0000_0201, 10'h201};

        idle_inputs();
        reset_n = 1'b0;
        repeat (3) begin tick_check(); tick_adv(); end
        reset_n = 1'b1;

        // Directed table: reset bubble, stall, redirect, kill+redirect
        for (int i = 0; i < 12; i++) begin
            fe1_stall = vecs[i].stall; ex_redirect = vecs[i].exr; ex_redirect_pc = vecs[i].exr_pc;
            csr_kill = vecs[i].kill; csr_redirect_pc = vecs[i].kill_pc; ex_fencei = 1'b0;
            tick_check();
            chk($sformatf("tbl%0d_valid", i), 32'(fe0_valid), 32'(vecs[i].e_valid));
            chk($sformatf("tbl%0d_addr", i),  32'(fe0_read_addr), 32'(vecs[i].e_addr));
            chk($sformatf("tbl%0d_spec", i),  32'(fe0_specid), 32'(vecs[i].e_spec));
            chk($sformatf("tbl%0d_cam", i),   32'(fe0_cam_read_addr), 32'(vecs[i].e_cam));
            chk($sformatf("tbl%0d_inval", i), 32'(fe0_cam_inval_req), 32'(vecs[i].e_inval));
            tick_adv();
        end

        // fence.i sweep; a redirect mid-sweep is ignored
        idle_inputs();
        ex_redirect = 1; ex_fencei = 1; ex_redirect_pc = 30'h50;
        tick_check(); chk("fencei_bubble", 32'(fe0_valid), 32'd0); tick_adv();
        idle_inputs();
        for (int i = 0; i < 256; i++) begin
            if (i == 50) begin ex_redirect = 1; ex_fencei = 1; ex_redirect_pc = 30'h999; end
            tick_check();
            chk("sweep_req", 32'(fe0_cam_inval_req), 32'd1);
            chk("sweep_idx", 32'(fe0_cam_inval_index), 32'(i));
            chk("sweep_done", 32'(fe0_fencei_done), 32'(i == 255));
            tick_adv();
            idle_inputs();
        end
        tick_check();
        chk("post_sweep_valid", 32'(fe0_valid), 32'd1);
        chk("post_sweep_addr", 32'(fe0_read_addr), 32'h50);
        tick_adv();

        // Sweep with csr_kill in the middle
        ex_redirect = 1; ex_fencei = 1; ex_redirect_pc = 30'h60;
        tick_check(); tick_adv(); idle_inputs();
        for (int i = 0; i < 256; i++) begin
            if (i == 100) begin csr_kill = 1; csr_redirect_pc = 30'h80; end
            tick_check();
            chk("sweep2_req", 32'(fe0_cam_inval_req), 32'd1);
            tick_adv();
            idle_inputs();
        end
        tick_check();
        chk("kill_sweep_addr", 32'(fe0_read_addr), 32'h80);
        chk("kill_sweep_valid", 32'(fe0_valid), 32'd1);
        tick_adv();

        // PC wrap
        csr_kill = 1; csr_redirect_pc = 30'h3FFF_FFFF;
        tick_check(); tick_adv(); idle_inputs();
        tick_check(); chk("wrap_top", 32'(fe0_read_addr), 32'h3FFF_FFFF); tick_adv();
        tick_check(); chk("wrap_zero", 32'(fe0_read_addr), 32'h0); tick_adv();

        // Reset during a sweep
        ex_redirect = 1; ex_fencei = 1; ex_redirect_pc = 30'h10;
        tick_check(); tick_adv(); idle_inputs();
        repeat (20) begin tick_check(); tick_adv(); end
        reset_n = 1'b0;
        tick_check(); tick_adv();
        tick_check();
        chk("rst_inval", 32'(fe0_cam_inval_req), 32'd0);
        chk("rst_done", 32'(fe0_fencei_done), 32'd0);
        chk("rst_valid", 32'(fe0_valid), 32'd0);
        tick_adv();
        reset_n = 1'b1;

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            int r;
            fe1_stall       = ($urandom_range(0, 99) < 30);
            r               = $urandom_range(0, 99);
            ex_redirect     = (r < 6);
            ex_fencei       = (r < 1) || ($urandom_range(0, 99) < 5);
            csr_kill        = ($urandom_range(0, 99) < 4);
            ex_redirect_pc  = 30'($urandom);
            csr_redirect_pc = 30'($urandom);
            reset_n         = ($urandom_range(0, 499) != 0);
            tick_check();
            tick_adv();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
